mole_game_core: RTL and testbench

- Parametrised successor to the three-mole game datapath. Drives NUM_MOLES one-hot mole outputs from an LFSR, times each mole with a programmable down-counter, scores hits and wrong presses, and counts timeouts up to a game-over limit.
- Sits between the level controller, which supplies speed and seed, and the score/LED display logic.

---
 rtl/mole_game_core.sv | 195 +++++++++++++++++++
 tb/tb_mole_game_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_core.sv
// Whack-a-mole datapath: LFSR-picked one-hot mole, per-mole timeout counter,
// hit/penalty scoring and a timeout count that ends the game.
module mole_game_core #(
  parameter int unsigned         NUM_MOLES  = 4,
  parameter int unsigned         IDX_W      = 2,
  parameter int unsigned         LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS  = 8'hB8,
  parameter int unsigned         CNT_W      = 28,
  parameter int unsigned         SCORE_W    = 8,
  parameter int unsigned         MISS_LIMIT = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 game,
  input  logic [LFSR_W-1:0]    seed,
  input  logic [CNT_W-1:0]     speed,
  input  logic [NUM_MOLES-1:0] buttons,
  output logic [NUM_MOLES-1:0] moles,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           misses,
  output logic                 hit,
  output logic                 miss,
  output logic                 game_over
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_GAP  = 3'd1;
  localparam logic [2:0] ST_PICK = 3'd2;
  localparam logic [2:0] ST_SHOW = 3'd3;
  localparam logic [2:0] ST_OVER = 3'd4;

  localparam logic [IDX_W:0]     NumMolesL  = (IDX_W + 1)'(NUM_MOLES);
  localparam logic [NUM_MOLES-1:0] OneHotL  = NUM_MOLES'(1);
  localparam logic [7:0]         MissLimitL = 8'(MISS_LIMIT);
  localparam logic [CNT_W-1:0]   CntOneL    = CNT_W'(1);
  localparam logic [SCORE_W-1:0] ScoreOneL  = SCORE_W'(1);
  localparam logic [LFSR_W-1:0]  LfsrOneL   = LFSR_W'(1);

  logic [2:0]           r_state;
  logic [LFSR_W-1:0]    r_lfsr;
  logic [CNT_W-1:0]     r_timer;
  logic [NUM_MOLES-1:0] r_btn_q;
  logic [NUM_MOLES-1:0] r_moles;
  logic [SCORE_W-1:0]   r_score;
  logic [7:0]           r_misses;
  logic                 r_hit;
  logic                 r_miss;
  logic                 r_over;

  logic [2:0]           w_state_nxt;
  logic [LFSR_W-1:0]    w_lfsr_nxt;
  logic [CNT_W-1:0]     w_timer_nxt;
  logic [NUM_MOLES-1:0] w_moles_nxt;
  logic [SCORE_W-1:0]   w_score_nxt;
  logic [7:0]           w_misses_nxt;
  logic                 w_hit_nxt;
  logic                 w_miss_nxt;
  logic                 w_over_nxt;

  logic [NUM_MOLES-1:0] w_press;
  logic                 w_any_press;
  logic                 w_good_press;
  logic [LFSR_W-1:0]    w_lfsr_adv;
  logic [IDX_W-1:0]     w_idx;
  logic [CNT_W-1:0]     w_gap_time;
  logic [SCORE_W-1:0]   w_score_up;
  logic [SCORE_W-1:0]   w_score_dn;
  logic [7:0]           w_misses_inc;

  always_comb begin
    w_press      = buttons & ~r_btn_q;
    w_any_press  = |w_press;
    w_good_press = |(w_press & r_moles);
    w_lfsr_adv   = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    w_idx        = w_lfsr_adv[IDX_W-1:0];
    w_gap_time   = speed >> 1;
    w_score_up   = (&r_score) ? r_score : r_score + ScoreOneL;
    w_score_dn   = (r_score == '0) ? r_score : r_score - ScoreOneL;
    w_misses_inc = r_misses + 8'd1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lfsr_nxt   = r_lfsr;
    w_timer_nxt  = r_timer;
    w_moles_nxt  = r_moles;
    w_score_nxt  = r_score;
    w_misses_nxt = r_misses;
    w_hit_nxt    = 1'b0;
    w_miss_nxt   = 1'b0;
    w_over_nxt   = r_over;

    // Dropping game parks the core but keeps the final result on display.
    if (!game) begin
      w_state_nxt = ST_IDLE;
      w_moles_nxt = '0;
      w_over_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_moles_nxt  = '0;
          w_score_nxt  = '0;
          w_misses_nxt = '0;
          w_lfsr_nxt   = (seed == '0) ? LfsrOneL : seed;
          w_timer_nxt  = w_gap_time;
          w_state_nxt  = ST_GAP;
        end
        ST_PICK: begin
          w_lfsr_nxt = w_lfsr_adv;
          if ({1'b0, w_idx} < NumMolesL) begin
            w_moles_nxt = OneHotL << w_idx;
            w_timer_nxt = speed;
            w_state_nxt = ST_SHOW;
          end else begin
            w_timer_nxt = w_gap_time;
            w_state_nxt = ST_GAP;
          end
        end
        ST_SHOW: begin
          // A correct press outranks both wrong presses and a same-cycle timeout.
          if (w_good_press) begin
            w_hit_nxt   = 1'b1;
            w_score_nxt = w_score_up;
            w_moles_nxt = '0;
            w_timer_nxt = w_gap_time;
            w_state_nxt = ST_GAP;
          end else if (w_any_press) begin
            w_score_nxt = w_score_dn;
          end else if (r_timer == '0) begin
            w_miss_nxt   = 1'b1;
            w_misses_nxt = w_misses_inc;
            w_moles_nxt  = '0;
            if (w_misses_inc == MissLimitL) begin
              w_over_nxt  = 1'b1;
              w_state_nxt = ST_OVER;
            end else begin
              w_timer_nxt = w_gap_time;
              w_state_nxt = ST_GAP;
            end
          end else begin
            w_timer_nxt = r_timer - CntOneL;
          end
        end
        ST_GAP: begin
          w_moles_nxt = '0;
          if (w_any_press) w_score_nxt = w_score_dn;
          if (r_timer == '0) w_state_nxt = ST_PICK;
          else               w_timer_nxt = r_timer - CntOneL;
        end
        ST_OVER: begin
          w_moles_nxt = '0;
          w_over_nxt  = 1'b1;
        end
        default: begin
          w_moles_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_lfsr   <= LfsrOneL;
      r_timer  <= '0;
      r_btn_q  <= '0;
      r_moles  <= '0;
      r_score  <= '0;
      r_misses <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_timer  <= w_timer_nxt;
      r_btn_q  <= buttons;
      r_moles  <= w_moles_nxt;
      r_score  <= w_score_nxt;
      r_misses <= w_misses_nxt;
      r_hit    <= w_hit_nxt;
      r_miss   <= w_miss_nxt;
      r_over   <= w_over_nxt;
    end
  end

  assign moles     = r_moles;
  assign score     = r_score;
  assign misses    = r_misses;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign game_over = r_over;

endmodule

// File: tb/tb_mole_game_core.sv
// Scoreboard bench for mole_game_core: directed scenarios push expected output
// events; a negedge monitor pops and compares each observed output change.
module tb_mole_game_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        game = 1'b0;
  logic [7:0]  seed = 8'h01;
  logic [27:0] speed = 28'd10;
  logic [3:0]  buttons = 4'b0;
  logic [3:0]  moles;
  logic [7:0]  score;
  logic [7:0]  misses;
  logic        hit, miss, game_over;

  logic        game3 = 1'b0;
  logic [7:0]  seed3 = 8'h06;
  logic [27:0] speed3 = 28'd4;
  logic [2:0]  buttons3 = 3'b0;
  logic [2:0]  moles3;
  logic [7:0]  score3;
  logic [7:0]  misses3;
  logic        hit3, miss3, game_over3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mole_game_core #(
    .NUM_MOLES(4), .IDX_W(2), .LFSR_W(8), .LFSR_TAPS(8'hB8),
    .CNT_W(28), .SCORE_W(8), .MISS_LIMIT(3)
  ) dut (
    .clock(clk), .reset_n(reset_n), .game(game), .seed(seed), .speed(speed),
    .buttons(buttons), .moles(moles), .score(score), .misses(misses),
    .hit(hit), .miss(miss), .game_over(game_over)
  );

  mole_game_core #(
    .NUM_MOLES(3), .IDX_W(2), .LFSR_W(8), .LFSR_TAPS(8'hB8),
    .CNT_W(28), .SCORE_W(8), .MISS_LIMIT(3)
  ) dut3 (
    .clock(clk), .reset_n(reset_n), .game(game3), .seed(seed3), .speed(speed3),
    .buttons(buttons3), .moles(moles3), .score(score3), .misses(misses3),
    .hit(hit3), .miss(miss3), .game_over(game_over3)
  );

  typedef struct {
    logic [3:0] moles;
    logic [7:0] score;
    logic [7:0] misses;
    logic       hit;
    logic       miss;
    logic       over;
    int         dt;
  } exp_t;

  exp_t q[$];

  task automatic push(input logic [3:0] m, input logic [7:0] s, input logic [7:0] mi,
                      input logic h, input logic x, input logic o, input int dt);
    exp_t e;
    e.moles = m; e.score = s; e.misses = mi; e.hit = h; e.miss = x; e.over = o; e.dt = dt;
    q.push_back(e);
  endtask

  // Monitor: an event is any change of the held outputs, or a hit/miss pulse.
  int          cyc = 0;
  int          last_cyc = 0;
  int          evt_n = 0;
  logic [20:0] prev_snap = '0;
  logic [20:0] cur_snap;
  exp_t        got_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cur_snap = {moles, score, misses, game_over};
    if (cur_snap !== prev_snap || hit || miss) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got moles=%h score=%0d misses=%0d hit=%b miss=%b over=%b, required no event",
                 moles, score, misses, hit, miss, game_over);
      end else begin
        got_e = q.pop_front();
        if (moles !== got_e.moles || score !== got_e.score || misses !== got_e.misses ||
            hit !== got_e.hit || miss !== got_e.miss || game_over !== got_e.over) begin
          errors++;
          $display("FAIL event%0d: got moles=%h score=%0d misses=%0d hit=%b miss=%b over=%b, required moles=%h score=%0d misses=%0d hit=%b miss=%b over=%b",
                   evt_n, moles, score, misses, hit, miss, game_over,
                   got_e.moles, got_e.score, got_e.misses, got_e.hit, got_e.miss, got_e.over);
        end
        if (got_e.dt >= 0) begin
          checks++;
          if (cyc - last_cyc != got_e.dt) begin
            errors++;
            $display("FAIL event%0d_spacing: got %0d cycles, required %0d",
                     evt_n, cyc - last_cyc, got_e.dt);
          end
        end
      end
      evt_n++;
      last_cyc = cyc;
      prev_snap = cur_snap;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_moles(input logic [3:0] target, input logic any, input int budget);
    int n = 0;
    logic found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clk);
      n++;
      if (any ? (moles != 4'b0) : (moles == target)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_moles: got timeout after %0d cycles, required moles=%h", n, target);
    end
  endtask

  initial begin
    int  n3;
    logic miss3_seen;

    #1 reset_n = 1'b0;
    #2;
    chk("rst_moles", 32'(moles), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_misses", 32'(misses), 32'h0);
    chk("rst_pulses", {30'b0, hit, miss}, 32'h0);
    chk("rst_game_over", 32'(game_over), 32'h0);
    chk("rst3_moles", 32'(moles3), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Three moles, seed 6: first pick indexes 3 (no mole), second lights mole 1.
    game3 = 1'b1;
    n3 = 0;
    miss3_seen = 1'b0;
    while (moles3 == 3'b0 && n3 < 50) begin
      @(negedge clk);
      n3++;
      if (miss3) miss3_seen = 1'b1;
    end
    chk("m3_first_mole_cycle", 32'(n3), 32'd9);
    chk("m3_first_mole", 32'(moles3), 32'h2);
    chk("m3_misses", 32'(misses3), 32'h0);
    chk("m3_no_miss_pulse", 32'(miss3_seen), 32'h0);
    game3 = 1'b0;

    // Scenario A: no presses, three timeouts end the game.
    push(4'h1, 8'd0, 8'd1 - 8'd1, 1'b0, 1'b0, 1'b0, -1);
    push(4'h0, 8'd0, 8'd1, 1'b0, 1'b1, 1'b0, 11);
    push(4'h1, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0, 7);
    push(4'h0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0, 11);
    push(4'h4, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, 7);
    push(4'h0, 8'd0, 8'd3, 1'b0, 1'b1, 1'b1, 11);
    @(negedge clk);
    seed = 8'h01; speed = 28'd10; game = 1'b1;
    drain(200);
    repeat (20) @(negedge clk);
    chk("over_held", 32'(game_over), 32'h1);
    chk("over_moles_dark", 32'(moles), 32'h0);
    chk("over_misses", 32'(misses), 32'd3);
    push(4'h0, 8'd0, 8'd3, 1'b0, 1'b0, 1'b0, -1);
    game = 1'b0;
    drain(10);

    // Scenario B: hit, held button, wrong presses, then drop game mid-show.
    push(4'h0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    push(4'h1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 7);
    push(4'h0, 8'd1, 8'd0, 1'b1, 1'b0, 1'b0, 3);
    push(4'h1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 7);
    push(4'h1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    push(4'h0, 8'd1, 8'd0, 1'b1, 1'b0, 1'b0, -1);
    push(4'h4, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 7);
    push(4'h0, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    game = 1'b1;
    wait_moles(4'h1, 1'b1, 100);
    repeat (2) @(negedge clk);
    buttons = 4'b0001;
    repeat (12) @(negedge clk);
    buttons = 4'b0010;
    @(negedge clk);
    buttons = 4'b0100;
    @(negedge clk);
    buttons = 4'b0001;
    @(negedge clk);
    buttons = 4'b0000;
    wait_moles(4'h4, 1'b1, 100);
    repeat (3) @(negedge clk);
    game = 1'b0;
    @(negedge clk);
    chk("drop_moles_dark", 32'(moles), 32'h0);
    chk("drop_score_held", 32'(score), 32'd1);
    drain(10);

    // Scenario C: restart repeats the sequence; hit coincident with timeout; reset.
    push(4'h0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    push(4'h1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 7);
    push(4'h0, 8'd0, 8'd1, 1'b0, 1'b1, 1'b0, 11);
    push(4'h1, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0, 7);
    push(4'h0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0, 11);
    push(4'h4, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, 7);
    push(4'h0, 8'd1, 8'd2, 1'b1, 1'b0, 1'b0, 11);
    push(4'h8, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 7);
    push(4'h0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    game = 1'b1;
    wait_moles(4'h4, 1'b0, 200);
    repeat (10) @(negedge clk);
    buttons = 4'b0110;
    @(negedge clk);
    buttons = 4'b0000;
    wait_moles(4'h8, 1'b0, 100);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    game = 1'b0;
    #1;
    chk("async_rst_moles", 32'(moles), 32'h0);
    chk("async_rst_score", 32'(score), 32'h0);
    chk("async_rst_misses", 32'(misses), 32'h0);
    chk("async_rst_flags", {29'b0, hit, miss, game_over}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drain(10);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
